// File: rtl/ibex_multdiv_issue.sv
// Issue/handshake wrapper between the decoder and the slow multiply/divide unit.
// Optional build macro IBEX_MULTDIV_ISSUE_ZERO_BYPASS_EN resolves trivial ops without the unit.
module ibex_multdiv_issue (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [1:0]  req_op_i,
   input  logic [1:0]  req_signed_mode_i,
   input  logic [31:0] req_op_a_i,
   input  logic [31:0] req_op_b_i,
   output logic        md_mult_en_o,
   output logic        md_div_en_o,
   output logic        md_mult_sel_o,
   output logic        md_div_sel_o,
   output logic [1:0]  md_operator_o,
   output logic [1:0]  md_signed_mode_o,
   output logic [31:0] md_op_a_o,
   output logic [31:0] md_op_b_o,
   output logic        md_ready_id_o,
   input  logic        md_valid_i,
   input  logic [31:0] md_result_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_result_o,
   output logic        busy_o,
   output logic [5:0]  latency_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam logic [1:0] OP_MULL = 2'd0;
   localparam logic [1:0] OP_MULH = 2'd1;
   localparam logic [1:0] OP_DIV  = 2'd2;
   localparam logic [1:0] OP_REM  = 2'd3;

   state_e      state_r;
   logic [5:0]  lat_cnt_r;
   logic        accept_s;
   logic        is_mul_s;
   logic        bypass_s;
   logic [31:0] bypass_result_s;
   logic [5:0]  lat_next_s;

   // Request acceptance, unit selection and saturating latency increment.
   always_comb begin
      accept_s   = req_valid_i & req_ready_o;
      is_mul_s   = (req_op_i == OP_MULL) || (req_op_i == OP_MULH);
      lat_next_s = (lat_cnt_r == 6'd63) ? 6'd63 : (lat_cnt_r + 6'd1);
   end

   // Detection of operations whose result is known without running the unit.
   always_comb begin
      bypass_s        = 1'b0;
      bypass_result_s = 32'd0;
`ifdef IBEX_MULTDIV_ISSUE_ZERO_BYPASS_EN
      case (req_op_i)
         OP_MULL, OP_MULH: begin
            if ((req_op_a_i == 32'd0) || (req_op_b_i == 32'd0)) begin
               bypass_s        = 1'b1;
               bypass_result_s = 32'd0;
            end else begin
               bypass_s        = 1'b0;
            end
         end
         OP_DIV: begin
            if (req_op_b_i == 32'd0) begin
               bypass_s        = 1'b1;
               bypass_result_s = 32'hFFFF_FFFF;
            end else begin
               bypass_s        = 1'b0;
            end
         end
         OP_REM: begin
            if (req_op_b_i == 32'd0) begin
               bypass_s        = 1'b1;
               bypass_result_s = req_op_a_i;
            end else begin
               bypass_s        = 1'b0;
            end
         end
         default: begin
            bypass_s        = 1'b0;
            bypass_result_s = 32'd0;
         end
      endcase
`else
      bypass_s        = 1'b0;
      bypass_result_s = 32'd0;
`endif
   end

   // Issue FSM; every output is a flop updated together with the state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r          <= ST_IDLE;
         lat_cnt_r        <= 6'd0;
         req_ready_o      <= 1'b1;
         md_mult_en_o     <= 1'b0;
         md_div_en_o      <= 1'b0;
         md_mult_sel_o    <= 1'b0;
         md_div_sel_o     <= 1'b0;
         md_operator_o    <= 2'd0;
         md_signed_mode_o <= 2'd0;
         md_op_a_o        <= 32'd0;
         md_op_b_o        <= 32'd0;
         md_ready_id_o    <= 1'b0;
         rsp_valid_o      <= 1'b0;
         rsp_result_o     <= 32'd0;
         busy_o           <= 1'b0;
         latency_o        <= 6'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  md_operator_o    <= req_op_i;
                  md_signed_mode_o <= req_signed_mode_i;
                  md_op_a_o        <= req_op_a_i;
                  md_op_b_o        <= req_op_b_i;
                  lat_cnt_r        <= 6'd0;
                  req_ready_o      <= 1'b0;
                  busy_o           <= 1'b1;
                  if (bypass_s) begin
                     state_r      <= ST_RESP;
                     rsp_valid_o  <= 1'b1;
                     rsp_result_o <= bypass_result_s;
                     latency_o    <= 6'd0;
                  end else begin
                     state_r       <= ST_WAIT;
                     md_mult_en_o  <= is_mul_s;
                     md_mult_sel_o <= is_mul_s;
                     md_div_en_o   <= ~is_mul_s;
                     md_div_sel_o  <= ~is_mul_s;
                     md_ready_id_o <= 1'b1;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               lat_cnt_r <= lat_next_s;
               // Drop the enables with the capture so the unit cannot restart.
               if (md_valid_i) begin
                  state_r       <= ST_RESP;
                  rsp_result_o  <= md_result_i;
                  latency_o     <= lat_next_s;
                  rsp_valid_o   <= 1'b1;
                  md_mult_en_o  <= 1'b0;
                  md_mult_sel_o <= 1'b0;
                  md_div_en_o   <= 1'b0;
                  md_div_sel_o  <= 1'b0;
                  md_ready_id_o <= 1'b0;
               end else begin
                  state_r <= ST_WAIT;
               end
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  state_r     <= ST_IDLE;
                  rsp_valid_o <= 1'b0;
                  busy_o      <= 1'b0;
                  req_ready_o <= 1'b1;
               end else begin
                  state_r <= ST_RESP;
               end
            end
            default: begin
               state_r       <= ST_IDLE;
               req_ready_o   <= 1'b1;
               md_mult_en_o  <= 1'b0;
               md_div_en_o   <= 1'b0;
               md_mult_sel_o <= 1'b0;
               md_div_sel_o  <= 1'b0;
               md_ready_id_o <= 1'b0;
               rsp_valid_o   <= 1'b0;
               busy_o        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// Self-checking bench: directed and random ops against an arithmetic reference of the mult/div result.
module tb_ibex_multdiv_issue;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [1:0]  req_op_i = 2'd0;
   logic [1:0]  req_signed_mode_i = 2'd0;
   logic [31:0] req_op_a_i = 32'd0;
   logic [31:0] req_op_b_i = 32'd0;
   logic        md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o;
   logic [1:0]  md_operator_o, md_signed_mode_o;
   logic [31:0] md_op_a_o, md_op_b_o;
   logic        md_ready_id_o;
   logic        md_valid_i = 1'b0;
   logic [31:0] md_result_i = 32'd0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic [31:0] rsp_result_o;
   logic        busy_o;
   logic [5:0]  latency_o;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   ibex_multdiv_issue dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_op_i(req_op_i), .req_signed_mode_i(req_signed_mode_i),
      .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i),
      .md_mult_en_o(md_mult_en_o), .md_div_en_o(md_div_en_o),
      .md_mult_sel_o(md_mult_sel_o), .md_div_sel_o(md_div_sel_o),
      .md_operator_o(md_operator_o), .md_signed_mode_o(md_signed_mode_o),
      .md_op_a_o(md_op_a_o), .md_op_b_o(md_op_b_o),
      .md_ready_id_o(md_ready_id_o),
      .md_valid_i(md_valid_i), .md_result_i(md_result_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
      .busy_o(busy_o), .latency_o(latency_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Architectural RISC-V M-extension result, computed with 64-bit arithmetic.
   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [1:0] sm,
                                              input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, r;
      logic [63:0] p;
      sa = sm[0] ? longint'($signed(a)) : longint'({32'd0, a});
      sb = sm[1] ? longint'($signed(b)) : longint'({32'd0, b});
      case (op)
         2'd0: begin r = sa * sb; p = r; return p[31:0]; end
         2'd1: begin r = sa * sb; p = r; return p[63:32]; end
         2'd2: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            r = sa / sb; p = r; return p[31:0];
         end
         default: begin
            if (b == 32'd0) return a;
            r = sa % sb; p = r; return p[31:0];
         end
      endcase
   endfunction

   function automatic bit ref_bypass(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef IBEX_MULTDIV_ISSUE_ZERO_BYPASS_EN
      if (op < 2'd2) return (a == 32'd0) || (b == 32'd0);
      return b == 32'd0;
`else
      return 1'b0;
`endif
   endfunction

   task automatic issue(input logic [1:0] op, input logic [1:0] sm, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk_i);
      chk("req_ready_idle", req_ready_o, 1);
      req_valid_i = 1'b1; req_op_i = op; req_signed_mode_i = sm;
      req_op_a_i = a; req_op_b_i = b;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      req_op_a_i = $urandom; req_op_b_i = $urandom; req_op_i = 2'($urandom);
   endtask

   // One full transaction: responder answers after `delay` WAIT cycles, writeback stalled `stall` cycles.
   task automatic do_op(input string tag, input logic [1:0] op, input logic [1:0] sm,
                        input logic [31:0] a, input logic [31:0] b, input int delay, input int stall);
      logic [31:0] exp_res;
      logic [5:0]  exp_lat;
      bit          byp, is_mul, stable;
      int          en_cnt, other_cnt;
      exp_res = ref_result(op, sm, a, b);
      byp     = ref_bypass(op, a, b);
      is_mul  = (op < 2'd2);
      exp_lat = byp ? 6'd0 : ((delay > 63) ? 6'd63 : 6'(delay));
      issue(op, sm, a, b);
      chk({tag, "_operator"}, md_operator_o, op);
      chk({tag, "_signed"}, md_signed_mode_o, sm);
      chk({tag, "_busy"}, busy_o, 1);
      chk({tag, "_req_ready_busy"}, req_ready_o, 0);
      if (!byp) begin
         chk({tag, "_md_ready_id"}, md_ready_id_o, 1);
         en_cnt = 0; other_cnt = 0; stable = 1'b1;
         for (int k = 1; k <= delay; k++) begin
            en_cnt    += is_mul ? int'(md_mult_en_o & md_mult_sel_o) : int'(md_div_en_o & md_div_sel_o);
            other_cnt += is_mul ? int'(md_div_en_o | md_div_sel_o) : int'(md_mult_en_o | md_mult_sel_o);
            if (md_op_a_o !== a || md_op_b_o !== b) stable = 1'b0;
            if (k == delay) begin
               md_valid_i = 1'b1; md_result_i = exp_res;
            end
            @(negedge clk_i);
         end
         md_valid_i = 1'b0; md_result_i = $urandom;
         chk({tag, "_en_cycles"}, en_cnt, delay);
         chk({tag, "_other_en"}, other_cnt, 0);
         chk({tag, "_ops_stable"}, stable, 1);
      end
      chk({tag, "_en_off"}, {md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o, md_ready_id_o}, 0);
      chk({tag, "_rsp_valid"}, rsp_valid_o, 1);
      chk({tag, "_result"}, rsp_result_o, exp_res);
      for (int s = 0; s < stall; s++) begin
         // Stray unit handshakes here must not disturb the held response.
         md_valid_i = 1'b1; md_result_i = ~exp_res;
         @(negedge clk_i);
         chk({tag, "_stall_valid"}, rsp_valid_o, 1);
         chk({tag, "_stall_result"}, rsp_result_o, exp_res);
         chk({tag, "_stall_req_ready"}, req_ready_o, 0);
      end
      md_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      chk({tag, "_done_valid"}, rsp_valid_o, 0);
      chk({tag, "_done_ready"}, req_ready_o, 1);
      chk({tag, "_done_busy"}, busy_o, 0);
      chk({tag, "_latency"}, latency_o, exp_lat);
      chk({tag, "_result_kept"}, rsp_result_o, exp_res);
   endtask

   initial begin
      logic [31:0] ra, rb;
      // Reset state.
      rst_i = 1'b1;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      chk("rst_req_ready", req_ready_o, 1);
      chk("rst_enables", {md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o, md_ready_id_o}, 0);
      chk("rst_fields", {md_operator_o, md_signed_mode_o}, 0);
      chk("rst_op_a", md_op_a_o, 0);
      chk("rst_op_b", md_op_b_o, 0);
      chk("rst_rsp", {rsp_valid_o, busy_o, latency_o}, 0);
      chk("rst_result", rsp_result_o, 0);

      // Directed scenarios.
      do_op("mull_7x6", 2'd0, 2'b00, 32'd7, 32'd6, 4, 0);
      do_op("div_neg7_2", 2'd2, 2'b11, 32'hFFFF_FFF9, 32'd2, 5, 1);
      do_op("rem_b0", 2'd3, 2'b00, 32'h0000_1234, 32'd0, 3, 0);
      do_op("div_b0", 2'd2, 2'b11, 32'h0000_0055, 32'd0, 2, 0);
      do_op("mul_a0", 2'd0, 2'b00, 32'd0, 32'h1234_5678, 2, 0);
      do_op("mulh_stall3", 2'd1, 2'b11, 32'h8000_0000, 32'h7FFF_FFFF, 2, 3);
      do_op("div_delay1", 2'd2, 2'b00, 32'd100, 32'd7, 1, 0);
      do_op("sat_70", 2'd2, 2'b00, 32'hFFFF_FFFF, 32'd3, 70, 0);

      // Reset pulsed in the middle of a DIV wait.
      issue(2'd2, 2'b11, 32'hFFFF_FFF9, 32'd2);
      chk("rstw_div_en", md_div_en_o, 1);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      chk("rstw_enables", {md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o, md_ready_id_o}, 0);
      chk("rstw_req_ready", req_ready_o, 1);
      chk("rstw_latency", latency_o, 0);
      chk("rstw_busy", busy_o, 0);
      chk("rstw_op_a", md_op_a_o, 0);
      do_op("mull_after_rst", 2'd0, 2'b00, 32'd123, 32'd1000, 3, 1);

      // Random ops, operands sometimes forced to zero.
      for (int i = 0; i < 24; i++) begin
         ra = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
         rb = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom);
         do_op("rand", 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ra, rb,
               $urandom_range(1, 9), $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
